non_max_suppression: RTL and testbench
======================================

// Module: non_max_suppression
// PURPOSE
//   Consumes the raster-order gradient stream (magnitude + 2-bit direction) produced by the
//   Sobel stage. Thins edges by zeroing every pixel that is not a local maximum along its
//   gradient direction. Sits between the Sobel stage and hysteresis thresholding.
//   Streaming only: one input per valid cycle, no backpressure.
// PARAMETERS
//   IMG_WIDTH   640  pixels per line (>=4)
//   IMG_HEIGHT  480  lines per frame (>=3)
// PORTS
//   clk              input   1  system clock, all logic on rising edge
//   rst              input   1  asynchronous, active-low reset
//   grad_mag         input   8  gradient magnitude (already saturated)
//   grad_dir         input   2  00 horiz grad, 01 diag NW-SE, 10 vert grad, 11 diag NE-SW
//   pixel_in_valid   input   1  qualifies grad_mag/grad_dir, raster order, gaps allowed
//   nms_mag          output  8  suppressed magnitude (kept value or 0)
//   pixel_out_valid  output  1  qualifies nms_mag
//   frame_done       output  1  one-cycle pulse coincident with last output of a frame
// BEHAVIOUR
//   - Reset (rst=0, async): nms_mag=0, pixel_out_valid=0, frame_done=0; col/row counters,
//     3x3 window and valid pipeline cleared. Line-buffer RAM is not cleared; stale contents
//     are always border-masked.
//   - Counters col (0..W-1) and row (0..H-1) advance only on pixel_in_valid.
//     col wraps W-1 -> 0 with row++; row wraps H-1 -> 0, i.e. the next frame starts.
//   - Stage 1 (on valid): shift the 3x3 window left.
//     New right column = {lb1[col] (row-2), lb0[col] (row-1), input (row)}.
//     Line buffers read-old-during-write: lb1[col]<=lb0[col], lb0[col]<=input.
//     Register qualifier q = (row>=1 && col>=1) and border = (row==1 || col==1).
//   - Window centre = pixel (row-1, col-1).
//     Exactly one output per qualifying input: (H-1)*(W-1) outputs per frame, covering
//     centres rows 0..H-2 and cols 0..W-2. Row H-1 and col W-1 are never emitted.
//   - Stage 2: if border, nms_mag=0. Otherwise compare centre mag M against two neighbours
//     selected by the centre's own dir. Keep M iff M > A and M >= B, else output 0:
//       00: A=left  B=right | 10: A=up  B=down | 11: A=SW  B=NE | 01: A=NW  B=SE
//     The asymmetric tie rule keeps only the leading pixel of a plateau.
//   - Latency: pixel_out_valid rises exactly 2 clk after the qualifying pixel_in_valid cycle.
//   - Input gap: pipeline stages advance only when their valid is set. With no new valid,
//     pixel_out_valid=0 and nms_mag holds its value. Output sequence is independent of gaps.
//   - frame_done=1 together with the output whose centre is (H-2, W-2).
//     Simultaneous frame wrap and new input needs no bubble.
//   - Magnitudes pass through unmodified at 8 bits. No arithmetic widening.
// STRUCTURE
//   - Shared package canny_pkg: DIR_H=2'b00, DIR_D_NWSE=2'b01, DIR_V=2'b10,
//     DIR_D_NESW=2'b11, and default IMG_WIDTH/IMG_HEIGHT constants.
//   - Sub-module nms_line_buffer: IMG_WIDTH x 10-bit {dir,mag} single-port RAM,
//     combinational read, read-old-during-write. Instantiated twice (lb0, lb1).
//   - Top level holds counters, window registers, compare logic and valid pipeline.
// TESTING (IMG_WIDTH=8, IMG_HEIGHT=6 unless noted)
//   1. Column 3 all mag=100 dir=00, rest mag=50 dir=00 -> centres in col 3 (rows 1..4)
//      = 100; all other outputs = 0.
//   2. Plateau: every row cols 2..5 mag=80 dir=00, rest 20 -> only col 2 (rows 1..4)
//      = 80; cols 3..5 = 0.
//   3. Diagonal dir=11 at centre (2,3) mag=120: NE(1,4)=130 -> 0.
//      NE=110, SW(3,2)=110 -> 120.
//   4. Constant frame mag=255 dir=00 -> exactly 35 outputs; row 0/col 0 centres = 0.
//      frame_done on the 35th only. Back-to-back second frame gives an identical result.
//   5. Random pixel_in_valid gaps (~40%) on scenario 1 data -> output sequence
//      bit-identical to gapless run; every output exactly 2 clk after its trigger.
//   6. rst low asynchronously at input pixel 20, mid-frame -> outputs and valid go 0
//      without waiting for clk. A full frame sent after release matches scenario 1.

Source files
------------

// File: rtl/canny_pkg.sv
// canny_pkg: shared gradient-direction codes, pixel record and frame defaults for the edge pipeline
package canny_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef enum logic [1:0] {
    DIR_H      = 2'b00,
    DIR_D_NWSE = 2'b01,
    DIR_V      = 2'b10,
    DIR_D_NESW = 2'b11
  } grad_dir_t;

  typedef struct packed {
    grad_dir_t  dir;
    logic [7:0] mag;
  } grad_pix_t;

  // strict against the trailing neighbour, inclusive against the leading one,
  // so a flat plateau survives only at its first pixel
  function automatic logic nms_keep(input logic [7:0] m, input logic [7:0] a, input logic [7:0] b);
    return (m > a) && (m >= b);
  endfunction

endpackage

// File: rtl/nms_line_buffer.sv
// nms_line_buffer: one image line of {dir,mag}, combinational read, returns old data during write
module nms_line_buffer
  import canny_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  grad_pix_t                wdata,
  output grad_pix_t                rdata
);

  grad_pix_t mem [DEPTH];

  assign rdata = mem[addr];

  // contents are never reset; the top level masks stale lines at the frame border
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

endmodule

// File: rtl/non_max_suppression.sv
// non_max_suppression: thins edges by keeping only local maxima along each pixel's gradient direction
module non_max_suppression
  import canny_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] grad_mag,
  input  logic [1:0] grad_dir,
  input  logic       pixel_in_valid,
  output logic [7:0] nms_mag,
  output logic       pixel_out_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            last_col;
  logic            last_row;
  grad_pix_t       pix_in;
  grad_pix_t       lb0_rd;
  grad_pix_t       lb1_rd;
  logic [2:0][7:0] top;
  logic [2:0][7:0] bot;
  grad_pix_t [2:0] mid;
  logic            q1;
  logic            border1;
  logic            last1;
  logic [7:0]      a;
  logic [7:0]      b;
  logic            keep;
  logic            unused;

  assign pix_in   = '{dir: grad_dir_t'(grad_dir), mag: grad_mag};
  assign last_col = col == CW'(IMG_WIDTH - 1);
  assign last_row = row == RW'(IMG_HEIGHT - 1);
  assign unused   = ^{lb1_rd.dir, mid[0].dir};

  nms_line_buffer #(.DEPTH(IMG_WIDTH)) lb0 (
    .clk  (clk),
    .we   (pixel_in_valid),
    .addr (col),
    .wdata(pix_in),
    .rdata(lb0_rd)
  );

  nms_line_buffer #(.DEPTH(IMG_WIDTH)) lb1 (
    .clk  (clk),
    .we   (pixel_in_valid),
    .addr (col),
    .wdata(lb0_rd),
    .rdata(lb1_rd)
  );

  // raster position of the incoming pixel; a frame wrap needs no idle cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pixel_in_valid) begin
      col <= last_col ? '0 : col + 1'b1;
      row <= last_col ? (last_row ? '0 : row + 1'b1) : row;
    end

  // stage 1: shift the 3x3 window left, newest column enters at index 2
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      top     <= '0;
      mid     <= '0;
      bot     <= '0;
      q1      <= 1'b0;
      border1 <= 1'b0;
      last1   <= 1'b0;
    end else begin
      q1 <= pixel_in_valid && row != '0 && col != '0;
      if (pixel_in_valid) begin
        top     <= {lb1_rd.mag, top[2:1]};
        mid     <= {lb0_rd, mid[2:1]};
        bot     <= {grad_mag, bot[2:1]};
        border1 <= row == RW'(1) || col == CW'(1);
        last1   <= last_row && last_col;
      end
    end

  // neighbour pair picked by the centre's own direction, A trailing and B leading
  always_comb begin
    a    = mid[1].dir == DIR_H ? mid[0].mag :
           mid[1].dir == DIR_V ? top[1] :
           mid[1].dir == DIR_D_NESW ? bot[0] : top[0];
    b    = mid[1].dir == DIR_H ? mid[2].mag :
           mid[1].dir == DIR_V ? bot[1] :
           mid[1].dir == DIR_D_NESW ? top[2] : bot[2];
    keep = !border1 && nms_keep(mid[1].mag, a, b);
  end

  // stage 2: registered result; magnitude holds across input gaps
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      nms_mag         <= '0;
      pixel_out_valid <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      pixel_out_valid <= q1;
      frame_done      <= q1 && last1;
      if (q1) nms_mag <= keep ? mid[1].mag : '0;
    end

endmodule

// File: tb/tb_non_max_suppression.sv
// tb_non_max_suppression: scoreboard bench for the edge-thinning stage on an 8x6 frame
module tb_non_max_suppression;
  import canny_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] grad_mag = '0;
  logic [1:0] grad_dir = '0;
  logic       pixel_in_valid = 1'b0;
  logic [7:0] nms_mag;
  logic       pixel_out_valid;
  logic       frame_done;

  non_max_suppression #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk            (clk),
    .rst            (rst),
    .grad_mag       (grad_mag),
    .grad_dir       (grad_dir),
    .pixel_in_valid (pixel_in_valid),
    .nms_mag        (nms_mag),
    .pixel_out_valid(pixel_out_valid),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mag;
    logic       done;
    int         cyc;
    int         r;
    int         c;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         outs = 0;
  int         dones = 0;
  logic [7:0] mimg [H][W];
  logic [1:0] dimg [H][W];
  logic [7:0] got  [H][W];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int r, input int c);
    logic [7:0] m, a, b;
    if (r == 0 || c == 0) return 8'd0;
    m = mimg[r][c];
    case (dimg[r][c])
      2'b00:   begin a = mimg[r][c-1];   b = mimg[r][c+1];   end
      2'b10:   begin a = mimg[r-1][c];   b = mimg[r+1][c];   end
      2'b11:   begin a = mimg[r+1][c-1]; b = mimg[r-1][c+1]; end
      default: begin a = mimg[r-1][c-1]; b = mimg[r+1][c+1]; end
    endcase
    return (m > a && m >= b) ? m : 8'd0;
  endfunction

  task automatic load(input int k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        dimg[r][c] = DIR_H;
        mimg[r][c] = k == 1 ? ((c == 3) ? 8'd100 : 8'd50) :
                     k == 2 ? ((c >= 2 && c <= 5) ? 8'd80 : 8'd20) :
                     k == 5 ? 8'd255 : 8'd10;
      end
    if (k == 3 || k == 4) begin
      dimg[2][3] = DIR_D_NESW;
      mimg[2][3] = 8'd120;
      mimg[1][4] = k == 3 ? 8'd130 : 8'd110;
      if (k == 4) mimg[3][2] = 8'd110;
    end
  endtask

  task automatic drive(input bit v, input int r, input int c);
    @(negedge clk);
    pixel_in_valid = v;
    grad_mag = v ? mimg[r][c] : 8'($urandom);
    grad_dir = v ? dimg[r][c] : 2'($urandom);
    if (v && r >= 1 && c >= 1)
      sb.push_back('{model(r-1, c-1), (r == H-1 && c == W-1), cyc, r-1, c-1});
  endtask

  task automatic send_frame(input int gap_pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(99) < gap_pct) drive(1'b0, 0, 0);
        drive(1'b1, r, c);
      end
  endtask

  task automatic drain();
    @(negedge clk);
    pixel_in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_left", sb.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && pixel_out_valid) begin
        outs++;
        if (frame_done) dones++;
        check("sb_avail", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          got[e.r][e.c] = nms_mag;
          check($sformatf("mag(%0d,%0d)", e.r, e.c), nms_mag, e.mag);
          check($sformatf("done(%0d,%0d)", e.r, e.c), frame_done, e.done);
          check($sformatf("latency(%0d,%0d)", e.r, e.c), cyc - e.cyc, 2);
        end
      end
    end
  endtask

  initial begin
    int o, d;
    fork monitor(); join_none
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mag", nms_mag, 0);
    check("rst_vld", pixel_out_valid, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b1;

    load(1); send_frame(0); drain();
    check("t1_col3", got[2][3], 100);
    check("t1_col2", got[2][2], 0);
    check("t1_col4", got[4][4], 0);

    load(2); send_frame(0); drain();
    check("t2_lead", got[3][2], 80);
    check("t2_inner", got[3][3], 0);
    check("t2_tail", got[3][5], 0);

    load(3); send_frame(0); drain();
    check("t3_ne_big", got[2][3], 0);
    load(4); send_frame(0); drain();
    check("t3_kept", got[2][3], 120);

    load(5);
    o = outs; d = dones;
    send_frame(0); send_frame(0); drain();
    check("t4_count", outs - o, 70);
    check("t4_dones", dones - d, 2);
    check("t4_row0", got[0][4], 0);
    check("t4_col0", got[3][0], 0);

    load(1); send_frame(40); drain();
    check("t5_col3", got[3][3], 100);

    load(1);
    for (int i = 0; i < 22; i++) drive(1'b1, i / W, i % W);
    @(posedge clk);
    #1;
    check("t6_pre_vld", pixel_out_valid, 1);
    check("t6_pre_mag", nms_mag, 100);
    rst = 1'b0;
    pixel_in_valid = 1'b0;
    #1;
    check("t6_async_mag", nms_mag, 0);
    check("t6_async_vld", pixel_out_valid, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_frame(0); drain();
    check("t6_col3", got[1][3], 100);
    check("t6_col5", got[1][5], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
